spu_line_fetch: RTL and testbench
=================================

// Module: spu_line_fetch
// PURPOSE
// - Memory responder for the SPU: serves 128-bit string-line reads from the 32-bit data memory port.
// - SPU issues a line request; the block fetches 4 consecutive words and returns one 128-bit line with a valid pulse.
// - Sits between the SPU (o_mem_addr/i_mem_data side) and the data-memory arbiter inside the MMU; the CPU has memory priority via mem_gnt.
// PARAMETERS
// - ADDR_W      32  byte-address width on both sides
// - LINE_WORDS  4   32-bit words per line; fixed at 4, line = 128 bits
// PORTS
// - clk            in   1       system clock (DCM CLK0)
// - rst            in   1       synchronous, active-high reset
// - spu_req        in   1       line request, sampled only when spu_busy=0
// - spu_addr       in   ADDR_W  byte address of line; bits [3:0] ignored (aligned down)
// - spu_busy       out  1       request in flight; new spu_req ignored
// - spu_rvalid     out  1       one-cycle pulse: spu_read_data holds the requested line
// - spu_read_data  out  128     line; word k (byte offset 4k) in bits [32k+31:32k]
// - mem_en         out  1       word read request to memory arbiter
// - mem_addr       out  ADDR_W  byte address of word, bits [1:0]=0
// - mem_gnt        in   1       arbiter grant; a read occurs only in cycles with mem_en&mem_gnt
// - mem_rdata      in   32      read data, valid exactly 1 cycle after a granted read
// - snoop_we       in   1       CPU data-memory write strobe (any byte lane)
// - snoop_addr     in   ADDR_W  CPU write byte address
// BEHAVIOUR
// - Reset: spu_busy=0, spu_rvalid=0, spu_read_data=0, mem_en=0, mem_addr=0, state IDLE, word counters 0.
// - States: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
// - IDLE: spu_req=1 latches line base {spu_addr[ADDR_W-1:4],4'h0}; next state FETCH; spu_busy=1 from the next cycle.
// - FETCH: mem_en=1, mem_addr=base+4*issue_cnt; issue_cnt increments only on mem_en&mem_gnt;
//   after the 4th granted read -> DRAIN. mem_gnt=0 holds mem_addr stable, with no timeout.
// - Capture: a 1-cycle-delayed grant flag with its word index; mem_rdata goes into that word slot.
//   Capture is pipelined with issue, so back-to-back grants give one word per cycle.
// - DRAIN: mem_en=0; waits for the final capture -> DONE.
// - DONE: spu_rvalid=1 for exactly one cycle; spu_busy stays 1 in this cycle; next state IDLE.
//   spu_read_data is held until the next line completes.
// - Latency, gnt always 1, req in cycle 0: mem_en in cycles 1-4, data captured cycles 2-5, spu_rvalid in cycle 6.
// - Each stalled grant cycle adds one cycle.
// - spu_req while busy, including the DONE cycle: ignored, never queued. SPU re-asserts after spu_rvalid.
// - Line addresses wrap modulo 2^ADDR_W; word increments never carry out of the 16-byte line.
// - rst mid-operation: next cycle all outputs take reset values, no spu_rvalid, partial data discarded.
// - snoop_* has no effect on the fetch path; it is used only by the optional cache.
// CONFIGURATION
// - Macro SPU_LINE_FETCH_CACHE_EN.
// - When defined: a one-line cache holds {valid, tag=addr[ADDR_W-1:4], data}. Every DONE loads it, valid=1.
// - Hit (IDLE, spu_req, valid, tag match): no memory traffic; spu_busy=1 and spu_rvalid=1 in the next cycle,
//   then IDLE. That cycle is DONE, so a request made during it is ignored.
// - snoop_we with snoop_addr[ADDR_W-1:4]==tag clears valid.
// - snoop_we hitting the in-flight line during FETCH/DRAIN: the line is still returned, but is loaded with valid=0.
// - When undefined: no cache storage; every request fetches from memory; snoop ports are unconnected inside the block.
// STRUCTURE
// - Package spu_mem_pkg: state encoding localparams (IDLE/FETCH/DRAIN/DONE), LINE_BYTES=16, LINE_OFF_W=4,
//   WORD_OFF_W=2, LINE_W=128.
// - Sub-module spu_line_cache: tag/valid/data plus hit and snoop-invalidate logic. Instantiated only under the macro.
// TESTING
// - rst, spu_req addr 0x100, gnt=1, mem returns 0x11,0x22,0x33,0x44
//   -> mem_addr 0x100..0x10C in cycles 1-4; spu_rvalid in cycle 6;
//   spu_read_data = 0x00000044_00000033_00000022_00000011.
// - addr 0x10F -> fetch starts at 0x100; addr 0xFFFFFFF0 -> mem_addr 0xFFFFFFF0..0xFFFFFFFC, no wrap into 0x0.
// - mem_gnt low for 3 cycles during the 2nd word -> mem_addr held at base+4; spu_rvalid in cycle 9; data correct.
// - spu_req held high continuously -> only one fetch per line; the following request is accepted the cycle after DONE.
// - rst asserted in cycle 3 of a fetch -> cycle 4: mem_en=0, spu_busy=0; no spu_rvalid in the next 10 cycles.
// - With SPU_LINE_FETCH_CACHE_EN: repeat addr 0x100 -> spu_rvalid 1 cycle after req, no mem_en.
//   snoop_we at 0x104 -> next req to 0x100 refetches from memory.

Source files
------------

// File: rtl/spu_mem_pkg.sv
// Shared constants, state encoding and capture payload for the SPU line-fetch path.
package spu_mem_pkg;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned LINE_OFF_W = 4;
  localparam int unsigned WORD_OFF_W = 2;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned WORD_IDX_W = LINE_OFF_W - WORD_OFF_W;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  // Delayed-grant marker: memory data for word idx is on the bus this cycle.
  typedef struct packed {
    logic      vld;
    word_idx_t idx;
  } cap_t;

endpackage

// File: rtl/spu_line_fetch_if.sv
// SPU request/response, data-memory arbiter and CPU snoop signals of the line fetcher.
interface spu_line_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  import spu_mem_pkg::*;

  logic              spu_req;
  logic [ADDR_W-1:0] spu_addr;
  logic              spu_busy;
  logic              spu_rvalid;
  logic [LINE_W-1:0] spu_read_data;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [WORD_W-1:0] mem_rdata;
  logic              snoop_we;
  logic [ADDR_W-1:0] snoop_addr;

  modport master (
    output spu_req, spu_addr, mem_gnt, mem_rdata, snoop_we, snoop_addr,
    input  spu_busy, spu_rvalid, spu_read_data, mem_en, mem_addr
  );

  modport slave (
    input  spu_req, spu_addr, mem_gnt, mem_rdata, snoop_we, snoop_addr,
    output spu_busy, spu_rvalid, spu_read_data, mem_en, mem_addr
  );

endinterface

// File: rtl/spu_line_cache.sv
// Single-line cache: tag/valid/data storage, lookup hit and CPU-write snoop invalidate.
module spu_line_cache
  import spu_mem_pkg::*;
#(
  parameter int unsigned TAG_W = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit_c,
  output logic [LINE_W-1:0] data,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic [LINE_W-1:0] load_data,
  input  logic              snoop_we,
  input  logic [TAG_W-1:0]  snoop_tag
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;

  assign hit_c = valid_q && (tag_q == lookup_tag);

  // A load wins over a same-cycle snoop; the caller folds that snoop into load_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data    <= '0;
    end else if (load_en) begin
      valid_q <= load_valid;
      tag_q   <= load_tag;
      data    <= load_data;
    end else if (snoop_we && (snoop_tag == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/spu_line_fetch.sv
// spu_line_fetch: builds a 128-bit line from four granted 32-bit reads and returns it to the SPU.
// Define SPU_LINE_FETCH_CACHE_EN to add a one-line cache with CPU-write snoop invalidate.
module spu_line_fetch
  import spu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic             clk,
  input logic             rst,
  spu_line_fetch_if.slave bus
);

  localparam int unsigned TAG_W    = ADDR_W - LINE_OFF_W;
  localparam word_idx_t   LAST_IDX = word_idx_t'(LINE_WORDS - 1);

  state_t            state, state_nxt;
  logic [TAG_W-1:0]  tag_q, req_tag_c;
  word_idx_t         issue_cnt, issue_inc_c;
  cap_t              cap_q;
  logic [LINE_W-1:0] line_buf, line_nxt_c, read_data_q, hit_data_c;
  logic              busy_q, rvalid_q, mem_en_q;
  logic              busy_nxt, rvalid_nxt, mem_en_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic              accept_c, grant_c, last_grant_c, last_cap_c, hit_c;

  assign req_tag_c    = bus.spu_addr[ADDR_W-1:LINE_OFF_W];
  assign accept_c     = (state == ST_IDLE) && bus.spu_req;
  assign grant_c      = mem_en_q && bus.mem_gnt;
  assign last_grant_c = grant_c && (issue_cnt == LAST_IDX);
  assign last_cap_c   = cap_q.vld && (cap_q.idx == LAST_IDX);
  assign issue_inc_c  = issue_cnt + word_idx_t'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept_c) state_nxt = hit_c ? ST_DONE : ST_FETCH;
      ST_FETCH: if (last_grant_c) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_cap_c) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered; the word index never carries into the tag.
  always_comb begin
    busy_nxt     = (state_nxt != ST_IDLE);
    rvalid_nxt   = (state_nxt == ST_DONE);
    mem_en_nxt   = (state_nxt == ST_FETCH);
    mem_addr_nxt = mem_addr_q;
    if (accept_c && !hit_c)
      mem_addr_nxt = {req_tag_c, {LINE_OFF_W{1'b0}}};
    else if (grant_c && !last_grant_c)
      mem_addr_nxt = {tag_q, issue_inc_c, {WORD_OFF_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      busy_q     <= busy_nxt;
      rvalid_q   <= rvalid_nxt;
      mem_en_q   <= mem_en_nxt;
      mem_addr_q <= mem_addr_nxt;
    end
  end

  always_comb begin
    line_nxt_c = line_buf;
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (cap_q.idx == word_idx_t'(k)) line_nxt_c[k*WORD_W +: WORD_W] = bus.mem_rdata;
    end
  end

  // Issue counter, delayed-grant capture pipe and line assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      issue_cnt   <= '0;
      cap_q       <= '0;
      line_buf    <= '0;
      read_data_q <= '0;
    end else begin
      if (accept_c) begin
        tag_q     <= req_tag_c;
        issue_cnt <= '0;
      end else if (grant_c) begin
        issue_cnt <= issue_inc_c;
      end
      cap_q.vld <= grant_c;
      cap_q.idx <= issue_cnt;
      if (cap_q.vld) begin
        line_buf <= line_nxt_c;
        if (last_cap_c) read_data_q <= line_nxt_c;
      end else if (accept_c && hit_c) begin
        read_data_q <= hit_data_c;
      end
    end
  end

`ifdef SPU_LINE_FETCH_CACHE_EN
  logic snoop_cur_c, snoop_req_c, dirty_q, load_valid_c;
  logic unused_addr_bits;

  assign snoop_cur_c  = bus.snoop_we && (bus.snoop_addr[ADDR_W-1:LINE_OFF_W] == tag_q);
  assign snoop_req_c  = bus.snoop_we && (bus.snoop_addr[ADDR_W-1:LINE_OFF_W] == req_tag_c);
  assign load_valid_c = !(dirty_q || snoop_cur_c);
  assign unused_addr_bits = ^{bus.spu_addr[LINE_OFF_W-1:0], bus.snoop_addr[LINE_OFF_W-1:0]};

  // A CPU write to the line in flight makes the returned copy uncacheable.
  always_ff @(posedge clk) begin
    if (rst)                                   dirty_q <= 1'b0;
    else if (accept_c)                         dirty_q <= snoop_req_c;
    else if (state != ST_IDLE && snoop_cur_c)  dirty_q <= 1'b1;
  end

  spu_line_cache #(.TAG_W(TAG_W)) u_cache (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (req_tag_c),
    .hit_c      (hit_c),
    .data       (hit_data_c),
    .load_en    (state == ST_DONE),
    .load_valid (load_valid_c),
    .load_tag   (tag_q),
    .load_data  (read_data_q),
    .snoop_we   (bus.snoop_we),
    .snoop_tag  (bus.snoop_addr[ADDR_W-1:LINE_OFF_W])
  );
`else
  logic unused_snoop;

  assign hit_c        = 1'b0;
  assign hit_data_c   = '0;
  assign unused_snoop = ^{bus.spu_addr[LINE_OFF_W-1:0], bus.snoop_we, bus.snoop_addr};
`endif

  assign bus.spu_busy      = busy_q;
  assign bus.spu_rvalid    = rvalid_q;
  assign bus.spu_read_data = read_data_q;
  assign bus.mem_en        = mem_en_q;
  assign bus.mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_spu_line_fetch.sv
// Bench for spu_line_fetch: line fetches under random addresses/grant patterns vs. a memory/line model.
module tb_spu_line_fetch;

  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spu_line_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  spu_line_fetch #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit          fixed_data;
  logic [31:0] mem_key;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (fixed_data) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return a ^ mem_key;
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(base + 32'(4*k));
    return l;
  endfunction

  // Memory: data for a granted read appears one cycle later, garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_gnt) bus.mem_rdata <= mem_word(bus.mem_addr);
    else                           bus.mem_rdata <= $urandom;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always granted, 1: random grants, 2: three stalls on the second word.
  task automatic fetch_line(input logic [31:0] addr, input int mode, input bit hold, input string name);
    logic [31:0]  base;
    logic [127:0] exp;
    int grants, stall, cyc, g4;
    bit g, seen;
    base = {addr[31:4], 4'h0};
    exp  = exp_line(base);
    grants = 0; stall = 0; g4 = 0; seen = 0;
`ifdef SPU_LINE_FETCH_CACHE_EN
    bus.snoop_we = 1'b1; bus.snoop_addr = base;
    step();
    bus.snoop_we = 1'b0;
`endif
    bus.spu_req = 1'b1; bus.spu_addr = addr; bus.mem_gnt = 1'b0;
    step();
    cyc = 1;
    if (!hold) begin
      bus.spu_req  = 1'b0;
      bus.spu_addr = $urandom;
    end
    while (!seen && cyc < 80) begin
      checks++;
      if (bus.spu_busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy cyc=%0d got=%b want=1", name, cyc, bus.spu_busy);
      end
      if (grants < 4) begin
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== base + 32'(4*grants)) begin
          failures++;
          $display("FAIL %s issue cyc=%0d got en=%b addr=%h want en=1 addr=%h",
                   name, cyc, bus.mem_en, bus.mem_addr, base + 32'(4*grants));
        end
        checks++;
        if (bus.spu_rvalid !== 1'b0) begin
          failures++;
          $display("FAIL %s early_rvalid cyc=%0d got=%b want=0", name, cyc, bus.spu_rvalid);
        end
        case (mode)
          0:       g = 1'b1;
          1:       g = ($urandom_range(0, 2) != 0);
          default: begin
            g = !(grants == 1 && stall < 3);
            if (!g) stall++;
          end
        endcase
        bus.mem_gnt = g;
        if (g) begin
          grants++;
          if (grants == 4) g4 = cyc;
        end
      end else begin
        bus.mem_gnt = 1'($urandom_range(0, 1));
        checks++;
        if (bus.mem_en !== 1'b0) begin
          failures++;
          $display("FAIL %s extra_issue cyc=%0d got en=%b want 0", name, cyc, bus.mem_en);
        end
        if (bus.spu_rvalid === 1'b1) begin
          seen = 1'b1;
          checks++;
          if (cyc != g4 + 2) begin
            failures++;
            $display("FAIL %s latency got cyc=%0d want cyc=%0d", name, cyc, g4 + 2);
          end
          checks++;
          if (bus.spu_read_data !== exp) begin
            failures++;
            $display("FAIL %s data got=%h want=%h", name, bus.spu_read_data, exp);
          end
        end
      end
      if (!seen) begin
        step();
        cyc++;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: no spu_rvalid within %0d cycles", name, cyc);
    end
    bus.mem_gnt = 1'b0;
    step();
    checks++;
    if (bus.spu_busy !== 1'b0 || bus.spu_rvalid !== 1'b0 || bus.mem_en !== 1'b0 ||
        bus.spu_read_data !== exp) begin
      failures++;
      $display("FAIL %s after_done got busy=%b rvalid=%b en=%b data=%h want 0/0/0 data=%h",
               name, bus.spu_busy, bus.spu_rvalid, bus.mem_en, bus.spu_read_data, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.spu_req = 1'b0; bus.spu_addr = '0; bus.mem_gnt = 1'b0;
    bus.snoop_we = 1'b0; bus.snoop_addr = '0;
    step(); step(); step();
    rst = 1'b0;
    checks++;
    if (bus.spu_busy !== 1'b0 || bus.spu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got busy=%b rvalid=%b want 0/0", bus.spu_busy, bus.spu_rvalid);
    end
    checks++;
    if (bus.mem_en !== 1'b0 || bus.mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem got en=%b addr=%h want 0/0", bus.mem_en, bus.mem_addr);
    end
    checks++;
    if (bus.spu_read_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want 0", bus.spu_read_data);
    end
  endtask

  task automatic test_basic();
    logic [127:0] want;
    want = 128'h00000044_00000033_00000022_00000011;
    fixed_data = 1'b1;
    fetch_line(32'h100, 0, 1'b0, "basic");
    checks++;
    if (bus.spu_read_data !== want) begin
      failures++;
      $display("FAIL basic_const got=%h want=%h", bus.spu_read_data, want);
    end
  endtask

  task automatic test_align();
    fixed_data = 1'b0;
    mem_key = $urandom;
    fetch_line(32'h10F, 0, 1'b0, "align_down");
    fetch_line(32'hFFFF_FFF0, 0, 1'b0, "top_line");
    fetch_line(32'hFFFF_FFFB, 1, 1'b0, "top_line_rand");
  endtask

  task automatic test_stall();
    fixed_data = 1'b1;
    fetch_line(32'h100, 2, 1'b0, "stall");
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    bit seen;
    fixed_data = 1'b0;
    mem_key = $urandom;
    addr = 32'h0000_2340;
    fetch_line(addr, 0, 1'b1, "hold");
    step();
    checks++;
`ifdef SPU_LINE_FETCH_CACHE_EN
    if (bus.spu_busy !== 1'b1 || bus.spu_rvalid !== 1'b1 || bus.mem_en !== 1'b0) begin
      failures++;
      $display("FAIL hold_reaccept got busy=%b rvalid=%b en=%b want 1/1/0",
               bus.spu_busy, bus.spu_rvalid, bus.mem_en);
    end
`else
    if (bus.spu_busy !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== addr) begin
      failures++;
      $display("FAIL hold_reaccept got busy=%b en=%b addr=%h want 1/1/%h",
               bus.spu_busy, bus.mem_en, bus.mem_addr, addr);
    end
`endif
    bus.spu_req = 1'b0;
    bus.mem_gnt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.spu_rvalid === 1'b1) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen || bus.spu_read_data !== exp_line(addr)) begin
      failures++;
      $display("FAIL hold_second got seen=%b data=%h want 1 data=%h",
               seen, bus.spu_read_data, exp_line(addr));
    end
    bus.mem_gnt = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int mode;
    fixed_data = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_key = $urandom;
      addr = $urandom;
      mode = $urandom_range(0, 2);
      fetch_line(addr, mode, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.spu_req = 1'b1; bus.spu_addr = 32'h200;
    step();
    bus.spu_req = 1'b0; bus.mem_gnt = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_gnt = 1'b0;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.spu_busy !== 1'b0 || bus.spu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl got en=%b busy=%b rvalid=%b want 0/0/0",
               bus.mem_en, bus.spu_busy, bus.spu_rvalid);
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.spu_read_data !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid_data got addr=%h data=%h want 0/0", bus.mem_addr, bus.spu_read_data);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.spu_rvalid !== 1'b0 || bus.mem_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got %0d active cycles want 0", bad);
    end
  endtask

`ifdef SPU_LINE_FETCH_CACHE_EN
  task automatic test_cache();
    bit seen;
    fixed_data = 1'b1;
    fetch_line(32'h100, 0, 1'b0, "cache_fill");
    bus.spu_req = 1'b1; bus.spu_addr = 32'h104;
    step();
    bus.spu_req = 1'b0;
    checks++;
    if (bus.spu_rvalid !== 1'b1 || bus.spu_busy !== 1'b1 || bus.mem_en !== 1'b0 ||
        bus.spu_read_data !== exp_line(32'h100)) begin
      failures++;
      $display("FAIL cache_hit got rvalid=%b busy=%b en=%b data=%h want 1/1/0",
               bus.spu_rvalid, bus.spu_busy, bus.mem_en, bus.spu_read_data);
    end
    step();
    bus.snoop_we = 1'b1; bus.snoop_addr = 32'h104;
    step();
    bus.snoop_we = 1'b0;
    bus.spu_req = 1'b1; bus.spu_addr = 32'h100;
    step();
    bus.spu_req = 1'b0;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.spu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cache_snoop got en=%b rvalid=%b want 1/0", bus.mem_en, bus.spu_rvalid);
    end
    bus.mem_gnt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.spu_rvalid === 1'b1) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL cache_refetch got no spu_rvalid want one");
    end
    bus.mem_gnt = 1'b0;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    fixed_data = 1'b1;
    mem_key = '0;
    test_reset();
    test_basic();
    test_align();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SPU_LINE_FETCH_CACHE_EN
    test_cache();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
